// File: rtl/blackbox_pkg.sv
// rtl/blackbox_pkg.sv - shared constants and offset-removal helper for the BlackBoxAdd datapath
//
// Purpose: default data width / offset constant and the wrapping subtract
// used to turn an offset value back into its original operand.
// Ports: none (package).
package blackbox_pkg;

  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_ADD_CONST = 1;
  localparam int COUNT_WIDTH       = 16;

  // Wrapping subtract on a 32-bit carrier; callers truncate to their own
  // width, which yields the result modulo 2^WIDTH for any WIDTH <= 32.
  function automatic logic [31:0] remove_offset(input logic [31:0] value,
                                                input logic [31:0] offset);
    return value - offset;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - power-of-two FIFO with extra-MSB pointers and occupancy
//
// Purpose: DEPTH-entry storage between the subtractor and the consumer.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   push, push_data       write request and data (ignored when full)
//   pop                   read request (ignored when empty)
//   pop_data              head entry, 0 when empty
//   full, empty           status flags derived from registered pointers
//   occupancy             number of stored entries, 0..DEPTH
module stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty     = (wr_ptr == rd_ptr);
  // Same slot but one lap apart: the writer has caught up with the reader.
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign occupancy = wr_ptr - rd_ptr;
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign pop_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only visible once a pointer covers it.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/blackbox_sub_stream.sv
// rtl/blackbox_sub_stream.sv - streaming offset removal with FIFO-buffered output
//
// Purpose: accepts offset values, subtracts ADD_CONST modulo 2^WIDTH and
// queues the recovered operands for the consumer.
// Ports:
//   clock, reset                       rising-edge clock, async active-high reset
//   io_in_valid/io_in_ready/io_in_bits    producer handshake and offset value
//   io_out_valid/io_out_ready/io_out_bits consumer handshake and recovered operand
//   io_count                           accepted inputs since reset, wrapping
//   io_occupancy                       current FIFO fill level
module blackbox_sub_stream
  import blackbox_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ADD_CONST = DEFAULT_ADD_CONST,
  parameter int DEPTH     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [WIDTH-1:0]       io_in_bits,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [WIDTH-1:0]       io_out_bits,
  output logic [COUNT_WIDTH-1:0] io_count,
  output logic [$clog2(DEPTH):0] io_occupancy
);

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] recovered;

  // Ready comes from registered state only, so a pop in the same cycle never
  // opens a slot early; the freed entry is offered on the following cycle.
  assign io_in_ready  = !full && !reset;
  assign io_out_valid = !empty;
  assign push         = io_in_valid && io_in_ready;
  assign pop          = io_out_valid && io_out_ready;
  assign recovered    = WIDTH'(remove_offset(32'(io_in_bits), 32'(ADD_CONST)));

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (recovered),
    .pop       (pop),
    .pop_data  (io_out_bits),
    .full      (full),
    .empty     (empty),
    .occupancy (io_occupancy)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_count <= '0;
    end else if (push) begin
      io_count <= io_count + 1'b1;
    end
  end

endmodule

// File: doc/blackbox_sub_stream.md
# blackbox_sub_stream

Streaming inverse stage for the BlackBoxAdd datapath. Accepts values already offset by ADD_CONST over a valid/ready handshake, subtracts ADD_CONST modulo 2^WIDTH, and buffers the results in a DEPTH-entry FIFO. The FIFO drives a registered valid/ready output. It sits downstream of the adder wrapper and returns the original operands to the consumer. It also reports the accepted-transaction count and the FIFO occupancy.

## Interface
- WIDTH, 16: data width in bits.
- ADD_CONST, 1: constant removed from each input, taken modulo 2^WIDTH.
- DEPTH, 4: FIFO entries; power of two, ≥ 2.

- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_in_valid  in  1  the producer presents io_in_bits.
- io_in_ready  out  1  the block can accept an input this cycle.
- io_in_bits  in  WIDTH  offset value (operand + ADD_CONST).
- io_out_valid  out  1  io_out_bits holds a recovered operand.
- io_out_ready  in  1  the consumer takes io_out_bits this cycle.
- io_out_bits  out  WIDTH  recovered operand.
- io_count  out  16  number of accepted inputs since reset; wraps.
- io_occupancy  out  clog2(DEPTH)+1  current number of FIFO entries.

## Operation
- Push: occurs when io_in_valid && io_in_ready. Stores (io_in_bits − ADD_CONST) mod 2^WIDTH at the write pointer.
- Pop: occurs when io_out_valid && io_out_ready. Advances the read pointer.
- io_in_ready = !full && !reset. It depends only on registered state; there is no combinational path from io_out_ready.
- io_out_valid = !empty. io_out_bits = mem[rd_ptr] when not empty, otherwise 0.
- Pointers are clog2(DEPTH)+1 bits wide and wrap naturally.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
- Simultaneous push and pop, neither full nor empty: occupancy is unchanged and both pointers advance.
- Empty with io_in_valid: the push proceeds. There is no same-cycle fall-through; io_out_valid does not rise until the next edge.
- Full: io_in_ready = 0 even if a pop happens in the same cycle. The freed slot is accepted one cycle later.
- Subtraction wraps, e.g. io_in_bits = 0x0000 with ADD_CONST = 1 gives 0xFFFF.
- io_count increments by 1 on each push and wraps from 0xFFFF to 0x0000.
- Holding io_out_bits stable while io_out_valid && !io_out_ready is required. The consumer may rely on it.
- Reset asserted at any time, including mid-transfer:
  - pointers, occupancy and count clear immediately;
  - buffered data is discarded;
  - no partial handshake completes in the cycle reset is asserted.

## Timing
- Reset values: io_in_ready = 0 while reset is high, then 1 in the first cycle after deassertion. io_out_valid = 0, io_out_bits = 0, io_count = 0, io_occupancy = 0.
- Latency: an input accepted at edge N is visible on io_out_bits, with io_out_valid = 1, in the cycle after edge N (1 cycle), provided the FIFO was empty.
- Throughput: one transfer per cycle sustained while 0 < occupancy < DEPTH and both sides are active.
- io_occupancy and io_count update on the same edge as the push or pop that changes them.

## Structure
- Shared package blackbox_pkg:
  - default WIDTH and ADD_CONST constants;
  - a function for offset removal (wrapping subtract), reused by the adder-side model in verification.
- One sub-module, stream_fifo:
  - parameterised WIDTH and DEPTH;
  - push/pop ports, full/empty flags and occupancy.
- The top level contains the subtractor and the io_count register.

## Test plan
- Reset then idle: all outputs at their reset values. io_in_ready = 1 one cycle after reset drops.
- Single transfer with io_out_ready = 1: in 0x0005 → io_out_bits 0x0004 one cycle later; io_count = 1, io_occupancy returns to 0.
- Wrap: in 0x0000 → out 0xFFFF. With ADD_CONST = 3, in 0x0001 → out 0xFFFE.
- Fill with io_out_ready = 0:
  - 4 pushes → io_occupancy = 4, io_in_ready = 0; a 5th valid is not accepted.
  - Raise io_out_ready → outputs appear in order; io_in_ready returns 1 cycle after the first pop.
- Streaming 100 random values with random valid/ready toggling: output sequence equals inputs − ADD_CONST in order; io_count = 100; io_out_bits stable while stalled.
- Reset asserted with occupancy 3: io_out_valid drops immediately and occupancy/count read 0. Post-reset, in 0x1234 → out 0x1233.
